// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_tx
//  Description : Host-to-device PS/2 transmitter. Sends one command byte to
//                the keyboard over the open-drain PS/2 clock/data lines
//                (inhibit, request-to-send, 11-bit frame, device ACK).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock (65 MHz)
//    rst          in   asynchronous reset, active low
//    tx_start     in   one-cycle send request, accepted only in IDLE
//    tx_data[7:0] in   byte to send, latched on accept
//    ps2_clk_in   in   raw PS/2 clock pin level (asynchronous)
//    ps2_data_in  in   raw PS/2 data pin level (asynchronous)
//    ps2_clk_oe   out  1 pulls the clock pin low, 0 releases it
//    ps2_data_oe  out  1 pulls the data pin low, 0 releases it
//    tx_busy      out  high from accept until return to IDLE
//    tx_done      out  one-cycle pulse: frame acknowledged and bus idle
//    tx_error     out  one-cycle pulse: NACK or timeout
// ============================================================================
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 6500,
   parameter int START_CYCLES   = 650,
   parameter int TIMEOUT_CYCLES = 975000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int c_FW = $clog2(FILTER_LEN + 1);
   localparam logic [c_FW-1:0] c_FLT_LAST   = c_FW'(FILTER_LEN - 1);
   localparam logic [c_FW-1:0] c_FLT_ONE    = c_FW'(1);
   localparam logic [19:0]     c_INH_LAST   = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0]     c_START_LAST = 20'(START_CYCLES - 1);
   localparam logic [19:0]     c_TO_LAST    = 20'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_INHIBIT   = 3'd1;
   localparam logic [2:0] c_RTS       = 3'd2;
   localparam logic [2:0] c_SEND      = 3'd3;
   localparam logic [2:0] c_ACK       = 3'd4;
   localparam logic [2:0] c_WAIT_IDLE = 3'd5;
   localparam logic [2:0] c_ERROR     = 3'd6;

   // -------------------------------------------------------------------------
   // Input conditioning: 2-FF synchronizer plus a run-length filter. The
   // filtered level flips only after FILTER_LEN consecutive samples that
   // disagree with it; r_fall is raised in the same cycle the filtered clock
   // drops to 0.
   // -------------------------------------------------------------------------
   logic            r_clk_s1, r_clk_s2, r_clk_filt;
   logic            r_dat_s1, r_dat_s2, r_dat_filt;
   logic [c_FW-1:0] r_clk_fcnt, r_dat_fcnt;
   logic            r_fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_filt <= 1'b1;
         r_clk_fcnt <= '0;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_dat_filt <= 1'b1;
         r_dat_fcnt <= '0;
         r_fall     <= 1'b0;
      end else begin
         r_clk_s1 <= ps2_clk_in;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data_in;
         r_dat_s2 <= r_dat_s1;
         r_fall   <= 1'b0;

         if (r_clk_s2 == r_clk_filt) begin
            r_clk_fcnt <= '0;
         end else if (r_clk_fcnt == c_FLT_LAST) begin
            r_clk_filt <= r_clk_s2;
            r_clk_fcnt <= '0;
            r_fall     <= ~r_clk_s2;
         end else begin
            r_clk_fcnt <= r_clk_fcnt + c_FLT_ONE;
         end

         if (r_dat_s2 == r_dat_filt) begin
            r_dat_fcnt <= '0;
         end else if (r_dat_fcnt == c_FLT_LAST) begin
            r_dat_filt <= r_dat_s2;
            r_dat_fcnt <= '0;
         end else begin
            r_dat_fcnt <= r_dat_fcnt + c_FLT_ONE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Transmit FSM. r_cnt times INHIBIT/RTS and doubles as the watchdog in
   // SEND/ACK/WAIT_IDLE. r_shift holds {stop, parity, D7..D0}, shifted out
   // LSB first, one bit per device clock fall.
   // -------------------------------------------------------------------------
   logic [2:0]  r_state;
   logic [19:0] r_cnt;
   logic [3:0]  r_bit_cnt;
   logic [9:0]  r_shift;
   logic        r_clk_oe, r_data_oe, r_busy, r_done, r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= c_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               if (tx_start) begin
                  // Odd parity is fixed here for the whole frame.
                  r_shift  <= {1'b1, ~(^tx_data), tx_data};
                  r_cnt    <= '0;
                  r_clk_oe <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= c_INHIBIT;
               end
            end
            c_INHIBIT: begin
               if (r_cnt == c_INH_LAST) begin
                  r_cnt     <= '0;
                  r_data_oe <= 1'b1;   // start bit
                  r_state   <= c_RTS;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            c_RTS: begin
               if (r_cnt == c_START_LAST) begin
                  r_cnt     <= '0;
                  r_bit_cnt <= '0;
                  r_clk_oe  <= 1'b0;
                  r_state   <= c_SEND;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            c_SEND: begin
               if (r_fall) begin
                  r_cnt     <= '0;
                  r_data_oe <= ~r_shift[0];
                  r_shift   <= {1'b0, r_shift[9:1]};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  // The tenth fall puts the stop bit (released line) out.
                  if (r_bit_cnt == 4'd9) begin
                     r_state <= c_ACK;
                  end
               end else if (r_cnt == c_TO_LAST) begin
                  r_cnt     <= '0;
                  r_data_oe <= 1'b0;
                  r_err     <= 1'b1;
                  r_state   <= c_ERROR;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            c_ACK: begin
               r_data_oe <= 1'b0;
               if (r_fall) begin
                  r_cnt <= '0;
                  if (!r_dat_filt) begin
                     r_state <= c_WAIT_IDLE;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= c_ERROR;
                  end
               end else if (r_cnt == c_TO_LAST) begin
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_state <= c_ERROR;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            c_WAIT_IDLE: begin
               // r_done is the pulse; the cycle it ends is the cycle busy drops.
               if (r_done) begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= c_IDLE;
               end else if (r_clk_filt && r_dat_filt) begin
                  r_done <= 1'b1;
               end else if (r_fall) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_TO_LAST) begin
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_state <= c_ERROR;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            c_ERROR: begin
               // r_err was raised on entry, so the pulse spans this state.
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_err     <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_busy     = r_busy;
   assign tx_done     = r_done;
   assign tx_error    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_tx
//  Description : Self-checking bench for ps2_tx with an open-drain PS/2
//                device model (40-cycle clock period) and a frame scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

   localparam int INH = 20;
   localparam int STA = 5;
   localparam int TO  = 2000;
   localparam int FL  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;

   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   bit         dev_ack = 1'b1;
   bit         dev_glitch = 1'b0;
   bit         dev_abort = 1'b0;
   int         dev_stall = 99;
   int         dev_falls = 0;
   int         last_fall = 0;
   int         cyc = 0;

   int         n_total = 0;
   int         n_bad = 0;

   logic [10:0] sb_q[$];

   // Open-drain bus: either side pulling low wins.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_tx #(
      .INHIBIT_CYCLES(INH),
      .START_CYCLES  (STA),
      .TIMEOUT_CYCLES(TO),
      .FILTER_LEN    (FL)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Device side of one host-to-device frame: clocks 10 bits, samples each on
   // the high phase, then clocks the ACK bit and compares against the queue.
   task automatic dev_frame();
      logic [10:0] bits;
      logic [10:0] exp;
      bits    = '0;
      bits[0] = ps2_data_in;
      repeat (20) @(negedge clk);
      for (int i = 1; i <= 10; i++) begin
         if (dev_abort || i > dev_stall) begin
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            return;
         end
         dev_clk_low = 1'b1;
         dev_falls++;
         last_fall = cyc;
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (5) @(negedge clk);
         if (dev_glitch && i == 4) begin
            dev_clk_low = 1'b1;
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (3) @(negedge clk);
         end else begin
            repeat (5) @(negedge clk);
         end
         bits[i] = ps2_data_in;
         repeat (10) @(negedge clk);
      end
      if (dev_abort) return;
      dev_data_low = dev_ack;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      dev_falls++;
      last_fall = cyc;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
      dev_data_low = 1'b0;
      check("sb_has_entry", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check("frame_bits", 32'(bits), 32'(exp));
      end
   endtask

   initial begin : dev_proc
      bit seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (ps2_clk_oe === 1'b1) begin
            seen = 1'b1;
         end else if (seen) begin
            seen = 1'b0;
            if (!ps2_data_in && !dev_abort) dev_frame();
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit push, input bit timing);
      int hi;
      int dat_at;
      hi     = 0;
      dat_at = -1;
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      if (push) sb_q.push_back({1'b1, ~^d, d, 1'b0});
      @(negedge clk);
      tx_start = 1'b0;
      if (timing) begin
         check("accept_clk_oe", 32'(ps2_clk_oe), 1);
         check("accept_busy", 32'(tx_busy), 1);
      end
      for (int k = 0; k < 400; k++) begin
         if (!ps2_clk_oe) break;
         if (ps2_data_oe && dat_at < 0) dat_at = k;
         hi++;
         @(negedge clk);
      end
      if (timing) begin
         check("clk_low_len", 32'(hi), 32'(INH + STA));
         check("data_oe_at", 32'(dat_at), 32'(INH));
      end
   endtask

   task automatic wait_end(input bit inject, output int nd, output int ne, output int ecyc);
      bit fin;
      fin  = 1'b0;
      nd   = 0;
      ne   = 0;
      ecyc = 0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         tx_start = inject && (k == 300);
         if (tx_start) tx_data = 8'hFF;
         if (tx_done) nd++;
         if (tx_error) begin
            if (ne == 0) ecyc = cyc;
            ne++;
         end
         if (!tx_busy) begin
            tx_start = 1'b0;
            fin = 1'b1;
            break;
         end
      end
      check("end_reached", 32'(fin), 1);
   endtask

   task automatic check_released(input string tag);
      check({tag, "_clk_oe"}, 32'(ps2_clk_oe), 0);
      check({tag, "_data_oe"}, 32'(ps2_data_oe), 0);
      check({tag, "_busy"}, 32'(tx_busy), 0);
   endtask

   initial begin
      int nd, ne, ecyc, delta, base;
      repeat (3) @(negedge clk);
      check("rst_clk_oe", 32'(ps2_clk_oe), 0);
      check("rst_data_oe", 32'(ps2_data_oe), 0);
      check("rst_busy", 32'(tx_busy), 0);
      check("rst_done", 32'(tx_done), 0);
      check("rst_error", 32'(tx_error), 0);
      rst = 1'b1;
      repeat (20) @(negedge clk);

      // 0xED with ACK, including request-to-send timing.
      send(8'hED, 1'b1, 1'b1);
      wait_end(1'b0, nd, ne, ecyc);
      check("ed_done_cnt", 32'(nd), 1);
      check("ed_err_cnt", 32'(ne), 0);
      repeat (5) @(negedge clk);
      check_released("ed_after");
      repeat (100) @(negedge clk);

      // Parity: 0x07 -> 0, 0x00 -> 1 (checked bit-exact by the device).
      foreach (sb_q[i]) ;
      for (int t = 0; t < 2; t++) begin
         logic [7:0] b;
         b = (t == 0) ? 8'h07 : 8'h00;
         send(b, 1'b1, 1'b0);
         wait_end(1'b0, nd, ne, ecyc);
         check("par_done_cnt", 32'(nd), 1);
         check("par_err_cnt", 32'(ne), 0);
         repeat (100) @(negedge clk);
      end

      // NACK: device leaves data high on the ACK clock.
      dev_ack = 1'b0;
      send(8'hA5, 1'b1, 1'b0);
      wait_end(1'b0, nd, ne, ecyc);
      check("nack_err_cnt", 32'(ne), 1);
      check("nack_done_cnt", 32'(nd), 0);
      repeat (2) @(negedge clk);
      check_released("nack_after");
      repeat (100) @(negedge clk);
      dev_ack = 1'b1;

      // Timeout: device stops after 4 clocks.
      dev_stall = 4;
      send(8'h3C, 1'b0, 1'b0);
      wait_end(1'b0, nd, ne, ecyc);
      delta = ecyc - last_fall;
      check("to_err_cnt", 32'(ne), 1);
      check("to_done_cnt", 32'(nd), 0);
      check("to_latency_in_range", 32'(delta >= TO && delta <= TO + FL + 8), 1);
      repeat (2) @(negedge clk);
      check_released("to_after");
      dev_stall = 99;
      repeat (100) @(negedge clk);

      // Busy request mid-frame plus a 2-cycle clock glitch.
      dev_glitch = 1'b1;
      send(8'h96, 1'b1, 1'b0);
      wait_end(1'b1, nd, ne, ecyc);
      check("busy_done_cnt", 32'(nd), 1);
      check("busy_err_cnt", 32'(ne), 0);
      repeat (100) @(negedge clk);
      dev_glitch = 1'b0;

      // Reset during bit 5, then a clean 0xF4 frame.
      base = dev_falls;
      send(8'h5A, 1'b0, 1'b0);
      for (int k = 0; k < 2000 && dev_falls < base + 5; k++) @(negedge clk);
      check("bit5_reached", 32'(dev_falls >= base + 5), 1);
      repeat (8) @(negedge clk);
      check("pre_rst_busy", 32'(tx_busy), 1);
      dev_abort = 1'b1;
      #2 rst = 1'b0;
      #1;
      check_released("async_rst");
      repeat (60) @(negedge clk);
      rst = 1'b1;
      dev_abort = 1'b0;
      repeat (20) @(negedge clk);
      send(8'hF4, 1'b1, 1'b0);
      wait_end(1'b0, nd, ne, ecyc);
      check("f4_done_cnt", 32'(nd), 1);
      check("f4_err_cnt", 32'(ne), 0);
      repeat (100) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the open-drain PS/2 clock and data lines. It is the transmit counterpart of `kb_interface`, which receives scan codes on the same lines. It runs in the 65 MHz domain next to `kb_interface`. `tx_busy` tells the receiver to discard line activity while a host frame is in progress.

## Interface
- `INHIBIT_CYCLES`, default 6500: clock-low request-to-send time (100 µs at 65 MHz).
- `START_CYCLES`, default 650: time data and clock are both held low before clock is released (10 µs).
- `TIMEOUT_CYCLES`, default 975000: maximum wait for any device clock edge or for bus idle (15 ms).
- `FILTER_LEN`, default 8: consecutive equal samples required to accept a new line level.
- `clk` input 1: 65 MHz system clock.
- `rst` input 1: asynchronous, active-low reset.
- `tx_start` input 1: one-cycle request; accepted only in IDLE.
- `tx_data` input 8: byte to send; latched when `tx_start` is accepted.
- `ps2_clk_in` input 1: raw PS/2 clock pin level (asynchronous).
- `ps2_data_in` input 1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe` output 1: 1 drives the clock pin low; 0 releases it to the pull-up.
- `ps2_data_oe` output 1: 1 drives the data pin low; 0 releases it.
- `tx_busy` output 1: high from accept until return to IDLE.
- `tx_done` output 1: one-cycle pulse when the frame is acknowledged and the bus is idle.
- `tx_error` output 1: one-cycle pulse on NACK or timeout.

## Operation
- **Input conditioning**
  - Each line passes through a 2-FF synchronizer, then a saturating filter.
  - The filtered level changes only after `FILTER_LEN` equal consecutive samples.
  - `fall` is a one-cycle strobe on a 1→0 transition of the filtered clock.
- **Frame:** 11 bits.
  - Start bit 0, then D0..D7 (LSB first), then odd parity (XOR of the data bits, inverted), then stop bit 1.
  - The device then drives the ACK bit (low).
  - The host drives a 0 bit by setting `ps2_data_oe`=1 and a 1 bit by setting `ps2_data_oe`=0.
- **IDLE:** both oe=0, `tx_busy`=0. If `tx_start`=1, latch `tx_data`, compute parity, load the shift register, and go to INHIBIT.
- **INHIBIT:** `ps2_clk_oe`=1, `ps2_data_oe`=0 for `INHIBIT_CYCLES` cycles, then go to RTS.
- **RTS:** `ps2_clk_oe`=1, `ps2_data_oe`=1 (start bit) for `START_CYCLES` cycles, then go to SEND and clear `bit_cnt`.
- **SEND:** `ps2_clk_oe`=0.
  - On each `fall`, drive the next bit and increment the 4-bit `bit_cnt`.
  - `fall` #1..#8 drive D0..D7, #9 drives parity, #10 drives stop (data released).
  - After fall #10, go to ACK.
- **ACK:** both oe=0.
  - On the next `fall`, sample filtered data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: NACK, go to ERROR.
- **WAIT_IDLE:** wait until filtered clock and data are both 1, then pulse `tx_done` and go to IDLE.
- **ERROR:** both oe=0, pulse `tx_error` for one cycle, go to IDLE.
- **Timeout**
  - A 20-bit watchdog is cleared on state entry and on every `fall`.
  - It counts in SEND, ACK and WAIT_IDLE.
  - Reaching `TIMEOUT_CYCLES` goes to ERROR.
- **Edge cases**
  - `tx_start` while busy is ignored; the latched byte is unchanged.
  - `tx_start` in the same cycle as a `tx_done` or `tx_error` pulse is ignored; the FSM is not yet in IDLE.
  - `fall` during INHIBIT or RTS is ignored.
- **Reset**
  - `rst`=0 at any time (including mid-frame) immediately forces IDLE.
  - Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_busy`=0, `tx_done`=0, `tx_error`=0, counters and shift register 0, filtered levels 1.

## Timing
- All outputs are registered.
- `tx_start` sampled at edge N: `ps2_clk_oe` and `tx_busy` are 1 from edge N+1.
- `ps2_clk_oe` stays 1 for `INHIBIT_CYCLES`+`START_CYCLES` cycles.
- `ps2_data_oe` rises exactly `INHIBIT_CYCLES` cycles after `ps2_clk_oe` rises.
- Pin falling edge to filtered `fall` strobe: 2 + `FILTER_LEN` cycles, ±1 for sampling phase.
- `ps2_data_oe` updates on the cycle after the `fall` strobe. This is well inside the ≥30 µs device clock-low phase.
- `tx_done` is asserted 1 cycle after both filtered lines read 1 in WAIT_IDLE.
- `tx_busy` falls in the same cycle the `tx_done` or `tx_error` pulse ends.
- Parity is fixed at accept; it is not recomputed while the frame is in progress.

## Test plan
Benches use `INHIBIT_CYCLES`=20, `START_CYCLES`=5, `TIMEOUT_CYCLES`=2000, `FILTER_LEN`=4, with a device model clocking at a 40-cycle period.
- **Send 0xED, device ACKs:**
  - Clock held low for 25 cycles; data low from cycle 20.
  - Device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `tx_done` pulses once; `tx_error` stays 0; both oe=0 afterwards.
- **Parity check:** send 0x07 → parity bit 0; send 0x00 → parity bit 1; device model verifies each frame bit-exact.
- **NACK:** device holds data high on the 11th clock → `tx_error`=1 for 1 cycle, `tx_done` stays 0, back to IDLE, lines released.
- **Timeout:** device stops clocking after 4 bits → `tx_error` 2000 cycles after the last `fall`, both oe=0.
- **Busy and glitches:**
  - Second `tx_start` with 0xFF mid-frame → ignored; device receives the original byte only.
  - 2-cycle clock glitch → no `fall`, no bit skipped.
- **Reset mid-frame:** `rst`=0 during SEND bit 5 → both oe=0 and `tx_busy`=0 asynchronously. After release, a new `tx_start` with 0xF4 sends a correct frame.
